cpu_reg_file: RTL and testbench

- Architectural register file of the GameBoy CPU, directly downstream of the ALU and feeding it.
- Sources the ALU 8-bit operands (op_A/op_B) and the current flags.
- Captures ALU results, next flags and 16-bit address results.
- Maintains PC and SP with the auto-increment/decrement the sequencer needs (HL+/HL-, PUSH/POP, opcode fetch).

---
 rtl/cpu_reg_file.sv | 219 +++++++++++++++++++++
 tb/tb_cpu_reg_file.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_reg_file.sv
// cpu_reg_file
// Architectural register file of the GameBoy CPU. It supplies the ALU with two
// 8-bit operands and the current flags. It captures 8-bit ALU results, flag
// updates and 16-bit pair writes. It also maintains PC and SP, and applies the
// HL+/HL-, PUSH/POP and fetch auto-steps.
//
// Parameters
//   SKIP_BOOT   1: reset to the DMG post-boot-ROM values, 0: reset everything to 0
// Ports
//   clk, rst              rising-edge clock; asynchronous active-high reset
//   rd_a_sel/rd_b_sel     8-bit read selects (0 B,1 C,2 D,3 E,4 H,5 L,6 F,7 A)
//   op_A/op_B             combinational 8-bit reads
//   wr_en/wr_sel/wr_data  8-bit write port (ALU result)
//   flag_we/flags_in      {Z,N,H,C} write port
//   flags                 current F[7:4]
//   pair_we/pair_sel/pair_data   16-bit write (0 BC,1 DE,2 HL,3 SP,4 AF,5 PC)
//   pair_rd_sel/pair_out  combinational 16-bit read; 6/7 read 0
//   hl_step/sp_step       01 +1, 10 -1, 00/11 hold
//   pc_inc, pc_out        PC increment strobe and current PC
module cpu_reg_file #(
    parameter bit SKIP_BOOT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  rd_a_sel,
    input  logic [2:0]  rd_b_sel,
    output logic [7:0]  op_A,
    output logic [7:0]  op_B,
    input  logic        wr_en,
    input  logic [2:0]  wr_sel,
    input  logic [7:0]  wr_data,
    input  logic        flag_we,
    input  logic [3:0]  flags_in,
    output logic [3:0]  flags,
    input  logic        pair_we,
    input  logic [2:0]  pair_sel,
    input  logic [15:0] pair_data,
    input  logic [2:0]  pair_rd_sel,
    output logic [15:0] pair_out,
    input  logic [1:0]  hl_step,
    input  logic [1:0]  sp_step,
    input  logic        pc_inc,
    output logic [15:0] pc_out
);

    typedef enum logic [2:0] {
        R_B = 3'd0, R_C = 3'd1, R_D = 3'd2, R_E = 3'd3,
        R_H = 3'd4, R_L = 3'd5, R_F = 3'd6, R_A = 3'd7
    } reg_sel_e;

    typedef enum logic [2:0] {
        P_BC = 3'd0, P_DE = 3'd1, P_HL = 3'd2,
        P_SP = 3'd3, P_AF = 3'd4, P_PC = 3'd5
    } pair_sel_e;

    typedef enum logic [1:0] {
        STEP_NONE = 2'b00, STEP_INC = 2'b01, STEP_DEC = 2'b10, STEP_NOP = 2'b11
    } step_e;

    logic [7:0]  reg_a, reg_b, reg_c, reg_d, reg_e, reg_h, reg_l;
    logic [3:0]  reg_f;
    logic [15:0] reg_sp, reg_pc;

    logic [7:0]  nxt_a, nxt_b, nxt_c, nxt_d, nxt_e, nxt_h, nxt_l;
    logic [3:0]  nxt_f;
    logic [15:0] nxt_sp, nxt_pc, hl_stepped;

    // Only F[7:4] is stored, so the low nibble of an AF write has nowhere to go.
    logic unused_pair_low;
    assign unused_pair_low = ^pair_data[3:0];

    // Next state. Each stage overrides the previous one: steps, then the pair
    // write, then the byte write, then the flag write.
    always_comb begin
        hl_stepped = {reg_h, reg_l};
        nxt_sp     = reg_sp;
        nxt_pc     = reg_pc;

        case (hl_step)
            STEP_INC: hl_stepped = {reg_h, reg_l} + 16'd1;
            STEP_DEC: hl_stepped = {reg_h, reg_l} - 16'd1;
            default:  hl_stepped = {reg_h, reg_l};
        endcase

        case (sp_step)
            STEP_INC: nxt_sp = reg_sp + 16'd1;
            STEP_DEC: nxt_sp = reg_sp - 16'd1;
            default:  nxt_sp = reg_sp;
        endcase

        if (pc_inc) begin
            nxt_pc = reg_pc + 16'd1;
        end

        nxt_a = reg_a;
        nxt_b = reg_b;
        nxt_c = reg_c;
        nxt_d = reg_d;
        nxt_e = reg_e;
        nxt_h = hl_stepped[15:8];
        nxt_l = hl_stepped[7:0];
        nxt_f = reg_f;

        if (pair_we) begin
            case (pair_sel)
                P_BC: {nxt_b, nxt_c} = pair_data;
                P_DE: {nxt_d, nxt_e} = pair_data;
                P_HL: {nxt_h, nxt_l} = pair_data;
                P_SP: nxt_sp = pair_data;
                P_AF: begin
                    nxt_a = pair_data[15:8];
                    nxt_f = pair_data[7:4];
                end
                P_PC: nxt_pc = pair_data;
                default: ;
            endcase
        end

        if (wr_en) begin
            case (wr_sel)
                R_B: nxt_b = wr_data;
                R_C: nxt_c = wr_data;
                R_D: nxt_d = wr_data;
                R_E: nxt_e = wr_data;
                R_H: nxt_h = wr_data;
                R_L: nxt_l = wr_data;
                R_F: nxt_f = wr_data[7:4];
                R_A: nxt_a = wr_data;
                default: ;
            endcase
        end

        if (flag_we) begin
            nxt_f = flags_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (SKIP_BOOT) begin
                reg_a  <= 8'h01;
                reg_f  <= 4'hB;
                reg_b  <= 8'h00;
                reg_c  <= 8'h13;
                reg_d  <= 8'h00;
                reg_e  <= 8'hD8;
                reg_h  <= 8'h01;
                reg_l  <= 8'h4D;
                reg_sp <= 16'hFFFE;
                reg_pc <= 16'h0100;
            end else begin
                reg_a  <= '0;
                reg_f  <= '0;
                reg_b  <= '0;
                reg_c  <= '0;
                reg_d  <= '0;
                reg_e  <= '0;
                reg_h  <= '0;
                reg_l  <= '0;
                reg_sp <= '0;
                reg_pc <= '0;
            end
        end else begin
            reg_a  <= nxt_a;
            reg_f  <= nxt_f;
            reg_b  <= nxt_b;
            reg_c  <= nxt_c;
            reg_d  <= nxt_d;
            reg_e  <= nxt_e;
            reg_h  <= nxt_h;
            reg_l  <= nxt_l;
            reg_sp <= nxt_sp;
            reg_pc <= nxt_pc;
        end
    end

    function automatic logic [7:0] read8(input logic [2:0] sel,
                                         input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d,
                                         input logic [7:0] e, input logic [7:0] h,
                                         input logic [7:0] l, input logic [3:0] f);
        logic [7:0] v;
        v = '0;
        case (sel)
            R_B: v = b;
            R_C: v = c;
            R_D: v = d;
            R_E: v = e;
            R_H: v = h;
            R_L: v = l;
            R_F: v = {f, 4'h0};
            R_A: v = a;
            default: v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        op_A = read8(rd_a_sel, reg_a, reg_b, reg_c, reg_d, reg_e, reg_h, reg_l, reg_f);
        op_B = read8(rd_b_sel, reg_a, reg_b, reg_c, reg_d, reg_e, reg_h, reg_l, reg_f);
    end

    always_comb begin
        pair_out = '0;
        case (pair_rd_sel)
            P_BC: pair_out = {reg_b, reg_c};
            P_DE: pair_out = {reg_d, reg_e};
            P_HL: pair_out = {reg_h, reg_l};
            P_SP: pair_out = reg_sp;
            P_AF: pair_out = {reg_a, reg_f, 4'h0};
            P_PC: pair_out = reg_pc;
            default: pair_out = '0;
        endcase
    end

    assign flags  = reg_f;
    assign pc_out = reg_pc;

endmodule

// File: tb/tb_cpu_reg_file.sv
// tb_cpu_reg_file
// Directed bench for cpu_reg_file. Two instances share all inputs: u0 has
// SKIP_BOOT=0 and u1 has SKIP_BOOT=1. Expected values are queued as stimulus is
// driven. They are popped and compared once the DUT should show them.
module tb_cpu_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rd_a_sel, rd_b_sel, wr_sel, pair_sel, pair_rd_sel;
    logic        wr_en, flag_we, pair_we, pc_inc;
    logic [7:0]  wr_data;
    logic [3:0]  flags_in;
    logic [15:0] pair_data;
    logic [1:0]  hl_step, sp_step;

    logic [7:0]  op_a0, op_b0, op_a1, op_b1;
    logic [3:0]  flags0, flags1;
    logic [15:0] pair_out0, pair_out1, pc_out0, pc_out1;

    int checks = 0;
    int errors = 0;

    // Observation points.
    localparam int O_OPA = 0, O_OPB = 1, O_FLG = 2, O_PAIR = 3, O_PC = 4,
                   O_PAIR1 = 5, O_PC1 = 6, O_FLG1 = 7;

    typedef struct {
        string       tag;
        int          obs;
        logic [2:0]  sel;
        logic [15:0] exp;
    } chk_t;

    chk_t sb[$];

    always #10 clk = ~clk;

    cpu_reg_file #(.SKIP_BOOT(1'b0)) u0 (
        .clk(clk), .rst(rst),
        .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel), .op_A(op_a0), .op_B(op_b0),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .flag_we(flag_we), .flags_in(flags_in), .flags(flags0),
        .pair_we(pair_we), .pair_sel(pair_sel), .pair_data(pair_data),
        .pair_rd_sel(pair_rd_sel), .pair_out(pair_out0),
        .hl_step(hl_step), .sp_step(sp_step), .pc_inc(pc_inc), .pc_out(pc_out0)
    );

    cpu_reg_file #(.SKIP_BOOT(1'b1)) u1 (
        .clk(clk), .rst(rst),
        .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel), .op_A(op_a1), .op_B(op_b1),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .flag_we(flag_we), .flags_in(flags_in), .flags(flags1),
        .pair_we(pair_we), .pair_sel(pair_sel), .pair_data(pair_data),
        .pair_rd_sel(pair_rd_sel), .pair_out(pair_out1),
        .hl_step(hl_step), .sp_step(sp_step), .pc_inc(pc_inc), .pc_out(pc_out1)
    );

    task automatic expect_val(input string tag, input int obs,
                              input logic [2:0] sel, input logic [15:0] exp);
        chk_t e;
        e.tag = tag;
        e.obs = obs;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // Compare every queued expectation against the current outputs.
    task automatic drain();
        chk_t        e;
        logic [15:0] got;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.obs)
                O_OPA:           rd_a_sel    = e.sel;
                O_OPB:           rd_b_sel    = e.sel;
                O_PAIR, O_PAIR1: pair_rd_sel = e.sel;
                default: ;
            endcase
            #1;
            case (e.obs)
                O_OPA:   got = {8'h00, op_a0};
                O_OPB:   got = {8'h00, op_b0};
                O_FLG:   got = {12'h000, flags0};
                O_PAIR:  got = pair_out0;
                O_PC:    got = pc_out0;
                O_PAIR1: got = pair_out1;
                O_PC1:   got = pc_out1;
                O_FLG1:  got = {12'h000, flags1};
                default: got = 'x;
            endcase
            checks++;
            assert (got === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, got, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        flag_we = 1'b0;
        pair_we = 1'b0;
        pc_inc  = 1'b0;
        hl_step = 2'b00;
        sp_step = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        rd_a_sel = 3'd7; rd_b_sel = 3'd0; pair_rd_sel = 3'd4;
        wr_sel = 3'd0; wr_data = 8'h00; flags_in = 4'h0;
        pair_sel = 3'd0; pair_data = 16'h0000;
        idle();
        #3;

        // Reset values for both parameterisations.
        expect_val("boot_af",  O_PAIR1, 3'd4, 16'h01B0);
        expect_val("boot_bc",  O_PAIR1, 3'd0, 16'h0013);
        expect_val("boot_de",  O_PAIR1, 3'd1, 16'h00D8);
        expect_val("boot_hl",  O_PAIR1, 3'd2, 16'h014D);
        expect_val("boot_sp",  O_PAIR1, 3'd3, 16'hFFFE);
        expect_val("boot_pc",  O_PC1,   3'd0, 16'h0100);
        expect_val("boot_flg", O_FLG1,  3'd0, 16'h000B);
        expect_val("rst_af",   O_PAIR,  3'd4, 16'h0000);
        expect_val("rst_sp",   O_PAIR,  3'd3, 16'h0000);
        expect_val("rst_pc",   O_PC,    3'd0, 16'h0000);
        expect_val("rst_flg",  O_FLG,   3'd0, 16'h0000);
        expect_val("rst_opa",  O_OPA,   3'd7, 16'h0000);
        expect_val("rst_opb",  O_OPB,   3'd1, 16'h0000);
        drain();
        rst = 1'b0;

        // Byte and flag write: invisible until the edge.
        wr_en = 1'b1; wr_sel = 3'd7; wr_data = 8'h3C;
        flag_we = 1'b1; flags_in = 4'b1010;
        expect_val("wr_pre_opa", O_OPA, 3'd7, 16'h0000);
        expect_val("wr_pre_flg", O_FLG, 3'd0, 16'h0000);
        drain();
        tick();
        idle();
        expect_val("wr_opa",  O_OPA,  3'd7, 16'h003C);
        expect_val("wr_flg",  O_FLG,  3'd0, 16'h000A);
        expect_val("wr_af",   O_PAIR, 3'd4, 16'h3CA0);
        expect_val("wr_opbf", O_OPB,  3'd6, 16'h00A0);
        drain();

        // HL increment/decrement wrap and the 11 no-op.
        pair_we = 1'b1; pair_sel = 3'd2; pair_data = 16'hFFFF;
        tick();
        idle();
        expect_val("hl_load", O_PAIR, 3'd2, 16'hFFFF);
        drain();
        hl_step = 2'b01;
        tick();
        expect_val("hl_inc_wrap", O_PAIR, 3'd2, 16'h0000);
        drain();
        hl_step = 2'b10;
        tick();
        expect_val("hl_dec_wrap", O_PAIR, 3'd2, 16'hFFFF);
        drain();
        hl_step = 2'b11;
        tick();
        expect_val("hl_nop", O_PAIR, 3'd2, 16'hFFFF);
        drain();
        idle();

        // Priority: the byte write beats the pair write, which beats the step.
        pair_we = 1'b1; pair_sel = 3'd2; pair_data = 16'h1234;
        hl_step = 2'b01;
        wr_en = 1'b1; wr_sel = 3'd5; wr_data = 8'h99;
        tick();
        idle();
        expect_val("prio_hl", O_PAIR, 3'd2, 16'h1299);
        drain();
        // The flag write beats the byte write to F.
        wr_en = 1'b1; wr_sel = 3'd6; wr_data = 8'hFF;
        flag_we = 1'b1; flags_in = 4'b0001;
        tick();
        idle();
        expect_val("prio_flg", O_FLG,  3'd0, 16'h0001);
        expect_val("prio_af",  O_PAIR, 3'd4, 16'h3C10);
        drain();

        // AF pair write drops the low nibble; the reserved pair is ignored and reads 0.
        pair_we = 1'b1; pair_sel = 3'd4; pair_data = 16'h12FF;
        tick();
        pair_sel = 3'd6; pair_data = 16'hBEEF;
        tick();
        idle();
        expect_val("af_pair",  O_PAIR, 3'd4, 16'h12F0);
        expect_val("rsv_read", O_PAIR, 3'd6, 16'h0000);
        expect_val("rsv_bc",   O_PAIR, 3'd0, 16'h0000);
        expect_val("rsv_hl",   O_PAIR, 3'd2, 16'h1299);
        drain();

        // An X select with its strobe low must not disturb anything.
        wr_sel = 'x; pair_sel = 'x;
        tick();
        expect_val("xsel_a",  O_OPA,  3'd7, 16'h0012);
        expect_val("xsel_hl", O_PAIR, 3'd2, 16'h1299);
        drain();

        // SP/PC concurrent stepping, alongside independent A and flag writes.
        pair_we = 1'b1; pair_sel = 3'd3; pair_data = 16'hFFFE;
        tick();
        pair_sel = 3'd5; pair_data = 16'h0150;
        tick();
        idle();
        sp_step = 2'b10; pc_inc = 1'b1;
        wr_en = 1'b1; wr_sel = 3'd7; wr_data = 8'h55;
        flag_we = 1'b1; flags_in = 4'b0110;
        tick();
        wr_en = 1'b0; flag_we = 1'b0;
        tick();
        tick();
        idle();
        expect_val("sp_dec3", O_PAIR, 3'd3, 16'hFFFB);
        expect_val("pc_inc3", O_PC,   3'd0, 16'h0153);
        expect_val("conc_a",  O_OPA,  3'd7, 16'h0055);
        expect_val("conc_f",  O_FLG,  3'd0, 16'h0006);
        drain();
        pair_we = 1'b1; pair_sel = 3'd5; pair_data = 16'hC000; pc_inc = 1'b1;
        tick();
        idle();
        expect_val("pc_pair_prio", O_PC, 3'd0, 16'hC000);
        drain();

        // PC and SP wrap.
        pair_we = 1'b1; pair_sel = 3'd5; pair_data = 16'hFFFF;
        tick();
        pair_sel = 3'd3; pair_data = 16'h0000; pc_inc = 1'b1;
        tick();
        idle();
        sp_step = 2'b10;
        tick();
        idle();
        expect_val("pc_wrap", O_PC,   3'd0, 16'h0000);
        expect_val("sp_wrap", O_PAIR, 3'd3, 16'hFFFF);
        drain();

        // Asynchronous reset between edges during activity.
        wr_en = 1'b1; wr_sel = 3'd7; wr_data = 8'h77; pc_inc = 1'b1;
        tick();
        expect_val("burst_a",  O_OPA, 3'd7, 16'h0077);
        expect_val("burst_pc", O_PC,  3'd0, 16'h0001);
        drain();
        #2 rst = 1'b1;
        expect_val("arst_a",    O_OPA,   3'd7, 16'h0000);
        expect_val("arst_pc",   O_PC,    3'd0, 16'h0000);
        expect_val("arst_pc1",  O_PC1,   3'd0, 16'h0100);
        expect_val("arst_af1",  O_PAIR1, 3'd4, 16'h01B0);
        drain();
        rst = 1'b0;
        wr_sel = 3'd0; wr_data = 8'h5A;
        tick();
        idle();
        expect_val("post_b",    O_PAIR,  3'd0, 16'h5A00);
        expect_val("post_a",    O_OPA,   3'd7, 16'h0000);
        expect_val("post_pc",   O_PC,    3'd0, 16'h0001);
        expect_val("post_pc1",  O_PC1,   3'd0, 16'h0101);
        expect_val("post_bc1",  O_PAIR1, 3'd0, 16'h5A13);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
